// File: rtl/seq_ctrl_pkg.sv
// Shared types and helpers for the programmable serial-pattern detector.
// Optional idle timeout in the top level is enabled with SEQ_CTRL_TIMEOUT_EN.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    CONFIGURED = 2'b01,
    ARMED      = 2'b10,
    DONE       = 2'b11
  } state_t;

  // Wide enough to hold every length from 0 up to and including pat_w.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    int unsigned r;
    if (len == 32'd0) begin
      r = 32'd1;
    end else if (len > max_len) begin
      r = max_len;
    end else begin
      r = len;
    end
    return r;
  endfunction

  function automatic int unsigned clamp_thresh(input int unsigned thresh);
    int unsigned r;
    if (thresh == 32'd0) begin
      r = 32'd1;
    end else begin
      r = thresh;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Shift-register matcher: compares the newest len bits (including the bit
// being sampled) against the pattern and reports a combinational match.
module seq_match_core
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,
  input  logic             clear,
  input  logic             sin,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic             ovl,
  output logic             match
);

  logic [PAT_W-1:0] shift_r;
  logic [PAT_W-1:0] shift_s;
  logic [PAT_W-1:0] mask_s;
  logic [LEN_W-1:0] fill_r;
  logic [LEN_W-1:0] fill_s;

  // Look-ahead values that include the bit arriving this cycle.
  always_comb begin
    shift_s = {shift_r[PAT_W-2:0], sin};
    fill_s  = (fill_r >= len) ? fill_r : fill_r + LEN_W'(1);
    mask_s  = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask_s[i] = (i < 32'(len));
    end
    match = sample && (fill_s >= len) && (((shift_s ^ pat) & mask_s) == '0);
  end

  // Shift and fill state; a non-overlapping match restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= '0;
      fill_r  <= '0;
    end else if (clear) begin
      shift_r <= '0;
      fill_r  <= '0;
    end else if (sample) begin
      if (match && !ovl) begin
        shift_r <= '0;
        fill_r  <= '0;
      end else begin
        shift_r <= shift_s;
        fill_r  <= fill_s;
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable pattern detection controller: configure / arm / count / done.
// Define SEQ_CTRL_TIMEOUT_EN to add the idle-timeout counter and timeout port.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter  int PAT_W = 8,
  parameter  int CNT_W = 8,
  parameter  int TO_W  = 16,
  localparam int LEN_W = len_w(PAT_W)
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             cfg_ovl,
  input  logic             start,
  input  logic             abort,
  input  logic             Sin,
  input  logic             Sin_valid,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done
`ifdef SEQ_CTRL_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  state_t           state_r;
  state_t           state_s;
  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic [CNT_W-1:0] thresh_r;
  logic             ovl_r;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             cfg_fire_s;
  logic             start_fire_s;
  logic             armed_s;
  logic             core_match_s;
  logic             match_ok_s;
  logic             to_fire_s;

  assign cfg_fire_s = cfg_valid && cfg_ready;
  assign armed_s    = (state_r == ARMED);
  // An abort in the same cycle as a match discards that match.
  assign match_ok_s = armed_s && core_match_s && !abort;
  assign cnt_inc_s  = match_cnt + CNT_W'(1);

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk    (CP),
    .rst    (CR),
    .sample (armed_s && Sin_valid),
    .clear  (start_fire_s),
    .sin    (Sin),
    .pat    (pat_r),
    .len    (len_r),
    .ovl    (ovl_r),
    .match  (core_match_s)
  );

  // Next state and next match count.
  always_comb begin
    state_s      = state_r;
    cnt_s        = match_cnt;
    start_fire_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cfg_fire_s) begin
          state_s = CONFIGURED;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      CONFIGURED, DONE: begin
        if (cfg_fire_s) begin
          state_s = CONFIGURED;
          cnt_s   = '0;
        end else if (start && !abort) begin
          state_s      = ARMED;
          cnt_s        = '0;
          start_fire_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ARMED: begin
        if (abort) begin
          state_s = CONFIGURED;
        end else if (match_ok_s) begin
          cnt_s   = cnt_inc_s;
          state_s = (cnt_inc_s >= thresh_r) ? DONE : ARMED;
        end else if (to_fire_s) begin
          state_s = CONFIGURED;
        end else begin
          state_s = ARMED;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_r   <= IDLE;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      hit       <= 1'b0;
      match_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      cfg_ready <= (state_s != ARMED);
      busy      <= (state_s == ARMED);
      hit       <= match_ok_s;
      match_cnt <= cnt_s;
      done      <= (state_s == DONE);
    end
  end

  // Configuration latch with length and threshold clamping.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      pat_r    <= '0;
      len_r    <= LEN_W'(1);
      thresh_r <= CNT_W'(1);
      ovl_r    <= 1'b0;
    end else if (cfg_fire_s) begin
      pat_r    <= cfg_pat;
      len_r    <= LEN_W'(clamp_len(32'(cfg_len), unsigned'(PAT_W)));
      thresh_r <= CNT_W'(clamp_thresh(32'(cfg_thresh)));
      ovl_r    <= cfg_ovl;
    end
  end

`ifdef SEQ_CTRL_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  logic [TO_W-1:0] to_cnt_r;

  // Fires on the cycle the idle count steps to its all-ones value.
  assign to_fire_s = armed_s && !abort && !match_ok_s && (to_cnt_r == TO_LAST);

  // Idle-cycle counter and one-cycle timeout pulse.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      to_cnt_r <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= to_fire_s;
      if (start_fire_s) begin
        to_cnt_r <= '0;
      end else if (armed_s) begin
        if (match_ok_s || abort) begin
          to_cnt_r <= '0;
        end else begin
          to_cnt_r <= to_cnt_r + TO_W'(1);
        end
      end
    end
  end
`else
  assign to_fire_s = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl.
module tb_seq_detect_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = 4;

  logic             CP = 1'b0;
  logic             CR;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_thresh;
  logic             cfg_ovl;
  logic             start;
  logic             abort;
  logic             Sin;
  logic             Sin_valid;
  logic             busy;
  logic             hit;
  logic [CNT_W-1:0] match_cnt;
  logic             done;
`ifdef SEQ_CTRL_TIMEOUT_EN
  logic             timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CP = ~CP;

  seq_detect_ctrl #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W),
    .TO_W  (4)
  ) dut (
    .CP         (CP),
    .CR         (CR),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pat    (cfg_pat),
    .cfg_len    (cfg_len),
    .cfg_thresh (cfg_thresh),
    .cfg_ovl    (cfg_ovl),
    .start      (start),
    .abort      (abort),
    .Sin        (Sin),
    .Sin_valid  (Sin_valid),
    .busy       (busy),
    .hit        (hit),
    .match_cnt  (match_cnt),
    .done       (done)
`ifdef SEQ_CTRL_TIMEOUT_EN
    ,
    .timeout    (timeout)
`endif
  );

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic configure(input logic [7:0] p, input logic [3:0] l,
                           input logic [7:0] t, input logic o);
    cfg_pat = p; cfg_len = l; cfg_thresh = t; cfg_ovl = o;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    Sin = b; Sin_valid = 1'b1;
    tick();
    Sin_valid = 1'b0;
  endtask

  task automatic test_reset();
    CR = 1'b1; cfg_valid = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_thresh = '0;
    cfg_ovl = 1'b0; start = 1'b0; abort = 1'b0; Sin = 1'b0; Sin_valid = 1'b0;
    #12;
    checks++;
    if ({cfg_ready, busy, hit, done} !== 4'b1000 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset rdy/busy/hit/done=%b cnt=%0d exp 1000 cnt=0",
               {cfg_ready, busy, hit, done}, match_cnt);
    end
    @(negedge CP);
    CR = 1'b0;
    arm();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_start busy=%b exp 0", busy);
    end
  endtask

  task automatic test_overlap();
    logic [5:0] bits = 6'b010101;
    logic [5:0] hits = 6'b000101;
    configure(8'h05, 4'd4, 8'd2, 1'b1);
    arm();
    checks++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL ovl_arm busy=%b rdy=%b exp 1 0", busy, cfg_ready);
    end
    for (int i = 5; i >= 0; i--) begin
      send_bit(bits[i]);
      checks++;
      if (hit !== hits[i]) begin
        errors++; $display("FAIL ovl_hit bit%0d got %b exp %b", 6 - i, hit, hits[i]);
      end
    end
    checks++;
    if (done !== 1'b1 || match_cnt !== 8'd2 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovl_done done=%b cnt=%0d busy=%b rdy=%b exp 1 2 0 1",
               done, match_cnt, busy, cfg_ready);
    end
    tick();
    checks++;
    if (hit !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL ovl_pulse hit=%b done=%b exp 0 1", hit, done);
    end
  endtask

  task automatic test_nonoverlap();
    logic [7:0] bits = 8'b01010101;
    logic [7:0] hits = 8'b00010001;
    configure(8'h05, 4'd4, 8'd2, 1'b0);
    checks++;
    if (done !== 1'b0 || match_cnt !== 8'd0) begin
      errors++; $display("FAIL reconfig_clear done=%b cnt=%0d exp 0 0", done, match_cnt);
    end
    arm();
    for (int i = 7; i >= 0; i--) begin
      send_bit(bits[i]);
      checks++;
      if (hit !== hits[i] || done !== (i == 0)) begin
        errors++;
        $display("FAIL novl bit%0d hit=%b done=%b exp %b %b", 8 - i, hit, done, hits[i], i == 0);
      end
    end
  endtask

  task automatic test_clamp();
    logic [7:0] bits = 8'hA5;
    configure(8'h01, 4'd0, 8'd0, 1'b0);
    arm();
    Sin = 1'b1; Sin_valid = 1'b0;
    tick();
    checks++;
    if (hit !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL clamp_gap hit=%b busy=%b exp 0 1", hit, busy);
    end
    send_bit(1'b1);
    checks++;
    if (hit !== 1'b1 || done !== 1'b1 || match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL clamp_hit hit=%b done=%b cnt=%0d exp 1 1 1", hit, done, match_cnt);
    end
    tick();
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL clamp_pulse hit=%b exp 0", hit);
    end
    configure(8'hA5, 4'd15, 8'd1, 1'b0);
    arm();
    for (int i = 7; i >= 0; i--) begin
      send_bit(bits[i]);
      checks++;
      if (hit !== (i == 0)) begin
        errors++; $display("FAIL lenclamp bit%0d hit=%b exp %b", 8 - i, hit, i == 0);
      end
    end
  endtask

  task automatic test_handshake_abort();
    logic [3:0] bits = 4'b0011;
    configure(8'h05, 4'd4, 8'd3, 1'b1);
    arm();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    cfg_pat = 8'h03; cfg_len = 4'd4; cfg_thresh = 8'd1; cfg_ovl = 1'b0;
    cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL stall cyc%0d rdy=%b busy=%b exp 0 1", i, cfg_ready, busy);
      end
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1 || match_cnt !== 8'd1 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort busy=%b rdy=%b cnt=%0d done=%b exp 0 1 1 0",
               busy, cfg_ready, match_cnt, done);
    end
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (match_cnt !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL stalled_cfg cnt=%0d busy=%b exp 0 0", match_cnt, busy);
    end
    arm();
    for (int i = 3; i >= 0; i--) begin
      send_bit(bits[i]);
      checks++;
      if (hit !== (i == 0) || done !== (i == 0)) begin
        errors++;
        $display("FAIL newcfg bit%0d hit=%b done=%b exp %b", 4 - i, hit, done, i == 0);
      end
    end
  endtask

  task automatic test_reset_midrun();
    configure(8'h05, 4'd4, 8'd3, 1'b1);
    arm();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    checks++;
    if (match_cnt !== 8'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL prerst cnt=%0d busy=%b exp 2 1", match_cnt, busy);
    end
    CR = 1'b1;
    #2;
    checks++;
    if ({cfg_ready, busy, hit, done} !== 4'b1000 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midrun_rst rdy/busy/hit/done=%b cnt=%0d exp 1000 0",
               {cfg_ready, busy, hit, done}, match_cnt);
    end
    @(negedge CP);
    CR = 1'b0;
    arm();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    checks++;
    if (busy !== 1'b0 || hit !== 1'b0 || match_cnt !== 8'd0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_noarm busy=%b hit=%b cnt=%0d rdy=%b exp 0 0 0 1",
               busy, hit, match_cnt, cfg_ready);
    end
  endtask

`ifdef SEQ_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    configure(8'h05, 4'd4, 8'd1, 1'b1);
    arm();
    Sin = 1'b1; Sin_valid = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if (timeout !== (i == 15) || busy !== (i != 15)) begin
        errors++;
        $display("FAIL timeout cyc%0d to=%b busy=%b exp %b %b", i, timeout, busy, i == 15, i != 15);
      end
    end
    Sin_valid = 1'b0;
    tick();
    checks++;
    if (timeout !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after to=%b rdy=%b busy=%b exp 0 1 0", timeout, cfg_ready, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_clamp();
    test_handshake_abort();
    test_reset_midrun();
`ifdef SEQ_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial-pattern detection controller. It sequences a shift-register matcher through configure, arm, count and done phases, and replaces hard-wired fixed-pattern detectors such as the 0101 detector. A host loads the pattern, length, match threshold and overlap mode over a valid/ready handshake, then starts a run. The block counts matches on the Sin stream and flags completion. It sits between the control host and the serial input path.

Parameters:
PAT_W, 8, maximum pattern length in bits
CNT_W, 8, match counter and threshold width
TO_W, 16, idle-timeout counter width (used only with the optional feature)

Ports:
CP  in  1  clock, rising edge
CR  in  1  asynchronous reset, active-high
cfg_valid  in  1  configuration offer
cfg_ready  out  1  configuration accepted when both cfg_valid and cfg_ready are high
cfg_pat  in  PAT_W  pattern; bit len-1 arrives first, bit 0 arrives last
cfg_len  in  LEN_W  pattern length; LEN_W = $clog2(PAT_W)+1
cfg_thresh  in  CNT_W  number of matches required to finish a run
cfg_ovl  in  1  1 = overlapping matches allowed
start  in  1  arm the detector
abort  in  1  stop the current run
Sin  in  1  serial data bit
Sin_valid  in  1  Sin is sampled this cycle
busy  out  1  high in ARMED
hit  out  1  one-cycle match pulse
match_cnt  out  CNT_W  matches counted in the current run
done  out  1  threshold reached; level output

Behaviour:
- Reset (CR=1, asynchronous):
  - state=IDLE, shift register and fill counter cleared.
  - Outputs: cfg_ready=1, busy=0, hit=0, match_cnt=0, done=0.
  - Applies in any state, mid-run included; the stored configuration is discarded.
- States:
  - IDLE: no valid configuration held.
  - CONFIGURED: configuration held, waiting for start.
  - ARMED: run in progress.
  - DONE: threshold reached.
- Configuration (cfg_ready=1 in IDLE, CONFIGURED and DONE; 0 in ARMED):
  - Handshake latches pat, len, thresh and ovl, then moves to CONFIGURED. done and match_cnt clear.
  - Clamping at latch: len=0 becomes 1; len>PAT_W becomes PAT_W; thresh=0 becomes 1.
  - cfg_valid while ARMED is stalled, not dropped.
- start:
  - In CONFIGURED or DONE: go to ARMED next cycle; clear shift register, fill and match_cnt; done falls.
  - In IDLE: ignored.
- abort:
  - In ARMED: go to CONFIGURED; match_cnt is held.
  - start and abort in the same cycle: abort wins.
- ARMED operation:
  - Each Sin_valid shifts Sin into bit 0 of the shift register. fill increments, saturating at len.
  - Match condition: fill (including the new bit) ≥ len and shift[len-1:0] == pat[len-1:0].
  - On a match, the following cycle: hit=1 and match_cnt increments.
  - If cfg_ovl=0, fill and the shift register clear on a match.
  - When match_cnt reaches thresh: state=DONE in the same cycle that hit is high; done=1 and busy=0.
- match_cnt never wraps: the run ends at thresh, which is ≤ 2^CNT_W−1.
- Sin_valid=0 holds the whole matcher. Sin is ignored outside ARMED.
- All outputs are registered; latency from the matching Sin sample to hit is 1 cycle.

Optional Feature:
- Macro: SEQ_CTRL_TIMEOUT_EN.
- Defined:
  - Adds output port timeout (1 bit).
  - A TO_W-bit counter counts consecutive ARMED cycles with no match. It clears on a hit and on start.
  - At count 2^TO_W−1: state goes to CONFIGURED and timeout pulses for one cycle.
- Not defined: no port, no counter; ARMED waits indefinitely.

Decomposition:
- Package seq_ctrl_pkg:
  - state encoding constants IDLE=2'b00, CONFIGURED=2'b01, ARMED=2'b10, DONE=2'b11.
  - LEN_W derivation.
  - Clamp helper functions for len and thresh.
- Sub-module seq_match_core:
  - Contents: shift register, fill counter, masked compare, ovl clear.
  - Inputs: sample enable, clear.
  - Output: combinational match.
- Top level: FSM, counters and handshake.

Test Plan:
- Reset mid-run: assert CR while ARMED with match_cnt=2 -> all outputs return to reset values immediately; start is ignored until a new configuration.
- Overlapping: pat=4'b0101, len=4, ovl=1, thresh=2; stream 0,1,0,1,0,1 -> hit after bits 4 and 6; done after bit 6; match_cnt=2.
- Non-overlapping: same configuration with ovl=0; stream 0,1,0,1,0,1,0,1 -> hit only after bits 4 and 8; done after bit 8.
- Clamping and gaps: len=0, thresh=0, pat bit0=1; stream 1 with Sin_valid low on alternate cycles -> one hit 1 cycle after the valid sample; done=1, match_cnt=1.
- Handshake and abort: cfg_valid held during ARMED -> cfg_ready=0 until abort; start and abort together -> state CONFIGURED, match_cnt held.
- SEQ_CTRL_TIMEOUT_EN with TO_W=4: arm and keep Sin constant with no match -> timeout pulse after 15 cycles; state CONFIGURED.
